// File: rtl/snake_game_ctrl.sv
// Game-state engine for the 32x24 VGA snake game: moves the head once per tick,
// detects wall and food hits, and places new food from a 10-bit LFSR.
module snake_game_ctrl #(
  parameter int          GRID_W    = 32,
  parameter int          GRID_H    = 24,
  parameter int          TICK_DIV  = 10_000_000,
  parameter int          START_X   = 16,
  parameter int          START_Y   = 12,
  parameter int          FOOD0_X   = 5,
  parameter int          FOOD0_Y   = 5,
  parameter int          MAX_LEN   = 63,
  parameter logic [9:0]  LFSR_SEED = 10'h2A5
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       btn_up,
  input  logic       btn_down,
  input  logic       btn_left,
  input  logic       btn_right,
  input  logic       start,
  output logic [4:0] snake_x,
  output logic [4:0] snake_y,
  output logic [4:0] yem_x,
  output logic [4:0] yem_y,
  output logic [5:0] snake_length,
  output logic       enable,
  output logic       game_over
);

  localparam int              CNT_W     = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [CNT_W-1:0] TICK_LAST = CNT_W'(TICK_DIV - 1);

  typedef enum logic [1:0] {IDLE, PLAY, PLACE, OVER} state_t;
  typedef enum logic [1:0] {DIR_UP, DIR_DOWN, DIR_LEFT, DIR_RIGHT} dir_t;

  state_t           state, state_next;
  dir_t             dir, dir_d, next_dir, next_dir_d, btn_dir, dir_eff;
  logic             btn_valid, step, hit_wall, hit_food, place_ok;
  logic [CNT_W-1:0] counter, counter_d;
  logic [9:0]       lfsr, lfsr_next;
  logic [5:0]       cand_x, cand_y;
  logic [4:0]       x_d, y_d, yem_x_d, yem_y_d, place_x, place_y;
  logic [5:0]       length_d;

  function automatic dir_t opposite(input dir_t d);
    case (d)
      DIR_UP:   return DIR_DOWN;
      DIR_DOWN: return DIR_UP;
      DIR_LEFT: return DIR_RIGHT;
      default:  return DIR_LEFT;
    endcase
  endfunction

  assign lfsr_next = {lfsr[8:0], lfsr[9] ^ lfsr[6]};
  assign place_x   = lfsr[4:0];
  assign place_y   = lfsr[9:5];
  assign place_ok  = ({1'b0, place_y} < 6'(GRID_H)) && ({1'b0, place_x} < 6'(GRID_W)) &&
                     !((place_x == snake_x) && (place_y == snake_y));

  assign step    = (state == PLAY) && (counter == TICK_LAST);
  // On a step the pending turn becomes the new heading, so reversal is judged against it.
  assign dir_eff = step ? next_dir : dir;

  always_comb begin
    btn_valid = 1'b1;
    btn_dir   = DIR_RIGHT;
    if      (btn_up)    btn_dir = DIR_UP;
    else if (btn_down)  btn_dir = DIR_DOWN;
    else if (btn_left)  btn_dir = DIR_LEFT;
    else if (btn_right) btn_dir = DIR_RIGHT;
    else                btn_valid = 1'b0;
  end

  always_comb begin
    cand_x = {1'b0, snake_x};
    cand_y = {1'b0, snake_y};
    case (next_dir)
      DIR_UP:    cand_y = {1'b0, snake_y} - 6'd1;
      DIR_DOWN:  cand_y = {1'b0, snake_y} + 6'd1;
      DIR_LEFT:  cand_x = {1'b0, snake_x} - 6'd1;
      DIR_RIGHT: cand_x = {1'b0, snake_x} + 6'd1;
    endcase
  end

  // An underflow wraps to 63, so a single upper-bound test also catches x<0 / y<0.
  assign hit_wall = (cand_x >= 6'(GRID_W)) || (cand_y >= 6'(GRID_H));
  assign hit_food = (cand_x[4:0] == yem_x) && (cand_y[4:0] == yem_y);

  always_comb begin
    // NOTE: every signal gets its hold value first so no path through the case infers a latch.
    state_next = state;
    counter_d  = counter;
    dir_d      = dir;
    next_dir_d = next_dir;
    x_d        = snake_x;
    y_d        = snake_y;
    yem_x_d    = yem_x;
    yem_y_d    = yem_y;
    length_d   = snake_length;
    case (state)
      IDLE: if (start) begin
        state_next = PLAY;
        counter_d  = '0;
      end
      PLAY: begin
        if (btn_valid && (btn_dir != opposite(dir_eff))) next_dir_d = btn_dir;
        if (step) begin
          counter_d = '0;
          dir_d     = next_dir;
          if (hit_wall) begin
            state_next = OVER;
          end else begin
            x_d = cand_x[4:0];
            y_d = cand_y[4:0];
            if (hit_food) begin
              length_d   = (snake_length >= 6'(MAX_LEN)) ? snake_length : snake_length + 6'd1;
              state_next = PLACE;
            end
          end
        end else begin
          counter_d = counter + 1'b1;
        end
      end
      PLACE: if (place_ok) begin
        yem_x_d    = place_x;
        yem_y_d    = place_y;
        state_next = PLAY;
      end
      OVER: if (start) begin
        state_next = PLAY;
        counter_d  = '0;
        dir_d      = DIR_RIGHT;
        next_dir_d = DIR_RIGHT;
        x_d        = 5'(START_X);
        y_d        = 5'(START_Y);
        yem_x_d    = 5'(FOOD0_X);
        yem_y_d    = 5'(FOOD0_Y);
        length_d   = 6'd1;
      end
    endcase
  end

  // NOTE: state is updated with non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= IDLE;
      counter      <= '0;
      dir          <= DIR_RIGHT;
      next_dir     <= DIR_RIGHT;
      snake_x      <= 5'(START_X);
      snake_y      <= 5'(START_Y);
      yem_x        <= 5'(FOOD0_X);
      yem_y        <= 5'(FOOD0_Y);
      snake_length <= 6'd1;
      enable       <= 1'b0;
      game_over    <= 1'b0;
      lfsr         <= LFSR_SEED;
    end else begin
      state        <= state_next;
      counter      <= counter_d;
      dir          <= dir_d;
      next_dir     <= next_dir_d;
      snake_x      <= x_d;
      snake_y      <= y_d;
      yem_x        <= yem_x_d;
      yem_y        <= yem_y_d;
      snake_length <= length_d;
      enable       <= (state_next != IDLE);
      game_over    <= (state_next == OVER);
      lfsr         <= lfsr_next;
    end
  end

endmodule

// File: tb/tb_snake_game_ctrl.sv
// Self-checking bench for snake_game_ctrl: a game-level model (integer head/food
// coordinates, direction vectors, arithmetic LFSR) is stepped alongside the DUT.
module tb_snake_game_ctrl;

  localparam int TICK  = 4;
  localparam int UP    = 0;
  localparam int DOWN  = 1;
  localparam int LEFT  = 2;
  localparam int RIGHT = 3;
  localparam int NONE  = -1;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       btn_up = 1'b0, btn_down = 1'b0, btn_left = 1'b0, btn_right = 1'b0;
  logic       start = 1'b0;
  logic [4:0] snake_x, snake_y, yem_x, yem_y;
  logic [5:0] snake_length;
  logic       enable, game_over;

  int n_tests = 0;
  int n_fail  = 0;

  typedef enum {M_IDLE, M_PLAY, M_PLACE, M_OVER} phase_e;
  phase_e m_phase;
  int hx, hy, fx, fy, len, cnt, mdir, mnext, lfsr, rejects, eats, placed;
  int dxs[4] = '{0, 0, -1, 1};
  int dys[4] = '{-1, 1, 0, 0};

  snake_game_ctrl #(.TICK_DIV(TICK)) dut (
    .clk(clk), .rst(rst),
    .btn_up(btn_up), .btn_down(btn_down), .btn_left(btn_left), .btn_right(btn_right),
    .start(start),
    .snake_x(snake_x), .snake_y(snake_y), .yem_x(yem_x), .yem_y(yem_y),
    .snake_length(snake_length), .enable(enable), .game_over(game_over)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic bit is_reverse(input int a, input int b);
    return (dxs[a] + dxs[b] == 0) && (dys[a] + dys[b] == 0);
  endfunction

  task automatic model_reset();
    m_phase = M_IDLE;
    hx = 16; hy = 12; fx = 5; fy = 5; len = 1; cnt = 0;
    mdir = RIGHT; mnext = RIGHT; lfsr = 'h2A5;
  endtask

  task automatic model_restart();
    hx = 16; hy = 12; fx = 5; fy = 5; len = 1; cnt = 0;
    mdir = RIGHT; mnext = RIGHT; m_phase = M_PLAY;
  endtask

  task automatic model_step();
    int nl, pick, newnext, nx, ny, cx, cy;
    bit is_step;
    placed = 0;
    if (rst) begin
      model_reset();
      return;
    end
    nl = (((lfsr << 1) | (((lfsr >> 9) ^ (lfsr >> 6)) & 1)) % 1024);
    case (m_phase)
      M_IDLE: if (start) begin m_phase = M_PLAY; cnt = 0; end
      M_PLAY: begin
        is_step = (cnt == TICK - 1);
        pick = btn_up ? UP : btn_down ? DOWN : btn_left ? LEFT : btn_right ? RIGHT : NONE;
        newnext = (pick != NONE && !is_reverse(pick, is_step ? mnext : mdir)) ? pick : mnext;
        if (is_step) begin
          cnt = 0;
          mdir = mnext;
          nx = hx + dxs[mdir];
          ny = hy + dys[mdir];
          if (nx < 0 || nx >= 32 || ny < 0 || ny >= 24) m_phase = M_OVER;
          else begin
            hx = nx; hy = ny;
            if (hx == fx && hy == fy) begin
              len = (len < 63) ? len + 1 : 63;
              eats++;
              m_phase = M_PLACE;
            end
          end
        end else cnt++;
        mnext = newnext;
      end
      M_PLACE: begin
        cx = lfsr % 32;
        cy = lfsr / 32;
        if (cy < 24 && !(cx == hx && cy == hy)) begin
          fx = cx; fy = cy; m_phase = M_PLAY; placed = 1;
        end else rejects++;
      end
      M_OVER: if (start) model_restart();
    endcase
    lfsr = nl;
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
  endtask

  task automatic set_btn(input int d);
    btn_up    = (d == UP);
    btn_down  = (d == DOWN);
    btn_left  = (d == LEFT);
    btn_right = (d == RIGHT);
  endtask

  function automatic logic [31:0] model_vec();
    return {5'(hx), 5'(hy), 5'(fx), 5'(fy), 6'(len), m_phase != M_IDLE, m_phase == M_OVER};
  endfunction

  function automatic logic [31:0] dut_vec();
    return {snake_x, snake_y, yem_x, yem_y, snake_length, enable, game_over};
  endfunction

  localparam logic [31:0] RESET_VEC = {5'd16, 5'd12, 5'd5, 5'd5, 6'd1, 1'b0, 1'b0};

  task automatic test_reset();
    rst = 1'b1;
    tick(); tick();
    n_tests++;
    if (dut_vec() !== RESET_VEC) begin
      n_fail++; $display("FAIL reset_values got=%h exp=%h", dut_vec(), RESET_VEC);
    end
    rst = 1'b0;
    set_btn(UP);
    for (int i = 0; i < 3; i++) begin
      tick();
      n_tests++;
      if (dut_vec() !== RESET_VEC) begin
        n_fail++; $display("FAIL idle_hold got=%h exp=%h", dut_vec(), RESET_VEC);
      end
    end
    set_btn(NONE);
  endtask

  task automatic test_straight();
    start = 1'b1; tick(); start = 1'b0;
    for (int k = 1; k <= 16; k++) begin
      tick();
      n_tests++;
      if (dut_vec() !== model_vec()) begin
        n_fail++; $display("FAIL straight_model k=%0d got=%h exp=%h", k, dut_vec(), model_vec());
      end
      n_tests++;
      if ({snake_x, snake_y, enable, game_over} !== {5'(16 + k / 4), 5'd12, 1'b1, 1'b0}) begin
        n_fail++; $display("FAIL straight_x k=%0d got x=%0d y=%0d exp x=%0d y=12", k, snake_x, snake_y, 16 + k / 4);
      end
    end
  endtask

  task automatic test_turns();
    set_btn(LEFT);
    for (int i = 0; i < 8; i++) begin
      tick();
      n_tests++;
      if (dut_vec() !== model_vec()) begin
        n_fail++; $display("FAIL reverse_model got=%h exp=%h", dut_vec(), model_vec());
      end
    end
    n_tests++;
    if ({snake_x, snake_y} !== {5'd22, 5'd12}) begin
      n_fail++; $display("FAIL reverse_ignored got=(%0d,%0d) exp=(22,12)", snake_x, snake_y);
    end
    set_btn(UP);
    for (int i = 0; i < 4; i++) tick();
    set_btn(NONE);
    n_tests++;
    if ({snake_x, snake_y} !== {5'd22, 5'd11}) begin
      n_fail++; $display("FAIL turn_up got=(%0d,%0d) exp=(22,11)", snake_x, snake_y);
    end
    for (int i = 0; i < 4; i++) tick();
    n_tests++;
    if ({snake_x, snake_y} !== {5'd22, 5'd10} || dut_vec() !== model_vec()) begin
      n_fail++; $display("FAIL turn_continue got=%h exp=%h", dut_vec(), model_vec());
    end
  endtask

  task automatic test_wall();
    int i;
    set_btn(LEFT); tick(); set_btn(NONE);
    for (i = 0; i < 200 && m_phase != M_OVER; i++) begin
      tick();
      n_tests++;
      if (dut_vec() !== model_vec()) begin
        n_fail++; $display("FAIL wall_model got=%h exp=%h", dut_vec(), model_vec());
      end
    end
    n_tests++;
    if (m_phase != M_OVER) begin
      n_fail++; $display("FAIL wall_timeout got phase=%0d exp OVER", m_phase);
    end
    n_tests++;
    if ({snake_x, snake_y, game_over} !== {5'd0, 5'd10, 1'b1}) begin
      n_fail++; $display("FAIL wall_stop got=(%0d,%0d,go=%b) exp=(0,10,go=1)", snake_x, snake_y, game_over);
    end
    for (int k = 0; k < 10; k++) begin
      set_btn(int'($urandom_range(0, 4)) - 1);
      tick();
      n_tests++;
      if (dut_vec() !== {5'd0, 5'd10, 5'd5, 5'd5, 6'd1, 1'b1, 1'b1}) begin
        n_fail++; $display("FAIL over_frozen got=%h exp=%h", dut_vec(), {5'd0, 5'd10, 5'd5, 5'd5, 6'd1, 1'b1, 1'b1});
      end
    end
    set_btn(NONE);
    start = 1'b1; tick(); start = 1'b0;
    n_tests++;
    if (dut_vec() !== {5'd16, 5'd12, 5'd5, 5'd5, 6'd1, 1'b1, 1'b0}) begin
      n_fail++; $display("FAIL restart got=%h exp=%h", dut_vec(), {5'd16, 5'd12, 5'd5, 5'd5, 6'd1, 1'b1, 1'b0});
    end
  endtask

  function automatic int steer();
    int eff, want;
    eff = (cnt == TICK - 1) ? mnext : mdir;
    if      (fx > hx) want = RIGHT;
    else if (fx < hx) want = LEFT;
    else if (fy > hy) want = DOWN;
    else if (fy < hy) want = UP;
    else return NONE;
    if (!is_reverse(want, eff)) return want;
    if (want == LEFT || want == RIGHT) return (fy > hy) ? DOWN : (fy < hy) ? UP : (hy > 0) ? UP : DOWN;
    return (hx > 0) ? LEFT : RIGHT;
  endfunction

  task automatic test_eat();
    int c, prev_fx, prev_fy;
    eats = 0; rejects = 0;
    for (c = 0; c < 30000 && eats < 63; c++) begin
      if (m_phase == M_OVER) begin start = 1'b1; set_btn(NONE); end
      else begin start = 1'b0; set_btn(m_phase == M_PLAY ? steer() : NONE); end
      prev_fx = fx; prev_fy = fy;
      tick();
      n_tests++;
      if (dut_vec() !== model_vec()) begin
        n_fail++; $display("FAIL eat_model cyc=%0d got=%h exp=%h", c, dut_vec(), model_vec());
      end
      if (placed != 0) begin
        n_tests++;
        if (yem_y >= 5'd24 || (yem_x == snake_x && yem_y == snake_y)) begin
          n_fail++; $display("FAIL food_placement got=(%0d,%0d) head=(%0d,%0d)", yem_x, yem_y, snake_x, snake_y);
        end
      end else if (m_phase == M_PLACE) begin
        n_tests++;
        if ({yem_x, yem_y} !== {5'(prev_fx), 5'(prev_fy)}) begin
          n_fail++; $display("FAIL food_held got=(%0d,%0d) exp=(%0d,%0d)", yem_x, yem_y, prev_fx, prev_fy);
        end
      end
    end
    start = 1'b0; set_btn(NONE);
    n_tests++;
    if (eats < 63 || snake_length !== 6'd63) begin
      n_fail++; $display("FAIL length_saturate got len=%0d eats=%0d exp len=63 eats>=63", snake_length, eats);
    end
    n_tests++;
    if (rejects == 0) begin
      n_fail++; $display("FAIL place_reject got rejects=0 exp >0");
    end
  endtask

  task automatic test_rst_priority();
    for (int i = 0; i < 6; i++) tick();
    rst = 1'b1; tick(); rst = 1'b0;
    n_tests++;
    if (dut_vec() !== RESET_VEC) begin
      n_fail++; $display("FAIL rst_in_play got=%h exp=%h", dut_vec(), RESET_VEC);
    end
    start = 1'b1; tick(); start = 1'b0;
    set_btn(UP); tick(); set_btn(NONE);
    for (int i = 0; i < 200 && m_phase != M_OVER; i++) tick();
    n_tests++;
    if (game_over !== 1'b1 || dut_vec() !== model_vec()) begin
      n_fail++; $display("FAIL reach_over got=%h exp=%h", dut_vec(), model_vec());
    end
    rst = 1'b1; start = 1'b1; tick(); rst = 1'b0; start = 1'b0;
    n_tests++;
    if (dut_vec() !== RESET_VEC) begin
      n_fail++; $display("FAIL rst_beats_start got=%h exp=%h", dut_vec(), RESET_VEC);
    end
    for (int i = 0; i < 3; i++) tick();
    n_tests++;
    if (dut_vec() !== RESET_VEC) begin
      n_fail++; $display("FAIL idle_after_rst got=%h exp=%h", dut_vec(), RESET_VEC);
    end
  endtask

  task automatic test_random();
    for (int c = 0; c < 3000; c++) begin
      set_btn(int'($urandom_range(0, 5)) - 1);
      start = ($urandom_range(0, 19) == 0);
      rst   = ($urandom_range(0, 299) == 0);
      tick();
      n_tests++;
      if (dut_vec() !== model_vec()) begin
        n_fail++; $display("FAIL random cyc=%0d got=%h exp=%h", c, dut_vec(), model_vec());
      end
    end
    rst = 1'b0; start = 1'b0; set_btn(NONE);
  endtask

  initial begin
    model_reset();
    test_reset();
    test_straight();
    test_turns();
    test_wall();
    test_eat();
    test_rst_priority();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/snake_game_ctrl.md
Name: snake_game_ctrl

Overview:
- Game-state engine for the VGA snake game on a 32x24 grid of 20x20-pixel cells.
- Sits directly upstream of the pixel generator. Drives the head cell, the food (yem) cell, the length, the snake-visible enable and the game_over flag that the pixel generator renders.
- Consumes debounced direction buttons and a start button.
- Moves the head one cell per movement tick, detects food and wall hits, and relocates food with an LFSR.

Parameters:
- GRID_W, 32, grid columns (valid x = 0..GRID_W-1).
- GRID_H, 24, grid rows (valid y = 0..GRID_H-1).
- TICK_DIV, 10_000_000, clk cycles per movement step (10 Hz at 100 MHz).
- START_X, 16, head x after reset/restart.
- START_Y, 12, head y after reset/restart.
- FOOD0_X, 5, food x after reset/restart.
- FOOD0_Y, 5, food y after reset/restart.
- MAX_LEN, 63, saturation value of snake_length.
- LFSR_SEED, 10'h2A5, non-zero LFSR reset value.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  synchronous active-high reset.
- btn_up  in  1  level, debounced, synchronous to clk.
- btn_down  in  1  level, debounced.
- btn_left  in  1  level, debounced.
- btn_right  in  1  level, debounced.
- start  in  1  level; starts or restarts the game.
- snake_x  out  5  head column.
- snake_y  out  5  head row.
- yem_x  out  5  food column.
- yem_y  out  5  food row.
- snake_length  out  6  eaten count + 1.
- enable  out  1  snake visible.
- game_over  out  1  game-over flag.

Behaviour:
- Interface: one clock (clk). Reset rst is synchronous, active-high, sampled on the rising edge of clk.
- All outputs are registered.
- Reset values:
  - state IDLE; snake_x=START_X, snake_y=START_Y; yem_x=FOOD0_X, yem_y=FOOD0_Y.
  - snake_length=1; enable=0; game_over=0; dir=RIGHT; tick counter=0; lfsr=LFSR_SEED.
- LFSR:
  - 10-bit Fibonacci, taps 10,7 (maximal length).
  - Advances every clk in every state except reset.
- States:
  - IDLE: enable=0. start=1 moves to PLAY; counter=0.
  - PLAY: enable=1. The counter counts 0..TICK_DIV-1. When counter==TICK_DIV-1 (a step), the counter wraps to 0 and the head moves one cell in dir.
  - PLACE: enable=1. Counter frozen; no moves.
  - OVER: enable=1, game_over=1. Head and food are frozen. start=1 reinitialises position, food, length, dir and counter to their reset values, clears game_over and moves to PLAY. The LFSR is not reinitialised.
- Direction:
  - Buttons are sampled every cycle in PLAY into next_dir.
  - Priority is up > down > left > right.
  - A press opposite to the current dir is ignored.
  - dir <= next_dir only on a step, before the move is computed for that step. This gives at most one turn per step.
- Move and wall:
  - Candidate head = head ±1, computed in 6 bits.
  - If the candidate x<0, x>=GRID_W, y<0 or y>=GRID_H, the head does not move and the next state is OVER. game_over rises in the cycle after the step.
- Eat:
  - If the candidate cell equals (yem_x, yem_y), the head moves there.
  - snake_length increments, saturating at MAX_LEN.
  - Next state is PLACE.
- PLACE:
  - Each cycle, the candidate food is x=lfsr[4:0], y=lfsr[9:5].
  - The candidate is accepted if y<GRID_H, x<GRID_W and (x,y) != head. On acceptance, yem is loaded and the block returns to PLAY, with the counter resuming from its frozen value.
  - If the candidate is rejected, the block retries next cycle. Termination is guaranteed by the LFSR period.
  - Food is never placed on the head.
- start held high while in PLAY or PLACE has no effect.
- Button inputs are ignored outside PLAY.
- rst asserted in any state returns all registers to their reset values on the next edge. rst has priority over start.

Test Plan (TICK_DIV=4):
1. Reset, then start pulse, then 4 steps with no buttons -> snake_x goes 17,18,19,20; snake_y stays 12. Exactly one move per 4 clks. enable=1, game_over=0.
2. Moving RIGHT with btn_left held -> dir unchanged and x keeps incrementing. Then btn_up for one step -> y decrements by 1 at the next step and x is unchanged.
3. Force head to (0,12) moving LEFT -> at the next step, head stays at (0,12), game_over=1 one cycle later, and the head is frozen thereafter. Then start -> head=(16,12), food=(5,5), length=1, game_over=0.
4. Steer head onto (5,5) -> snake_length goes 1->2. New yem is within 0..31 x 0..23 and differs from the head. No head move occurs while in PLACE.
5. Force the LFSR to yield y>=24 on the first candidate -> yem is not updated that cycle. The first valid candidate is accepted later.
6. Assert rst mid-PLAY, and also in OVER with start high in the same cycle -> all outputs return to reset values and the state is IDLE (rst wins).
